// File: rtl/ram_rw_host.sv
// Purpose : host-side initiator for the UART RAM loader protocol (CPU_RST/CPU_RUN/LOAD/DUMP).
// Latency : first protocol byte is valid 1 cycle after request accept; done_o 1 cycle after last handshake.
// Backpressure: single tx byte register reloads on handshake (no bubble); wr/rd streams follow tx/rx ready.
// Optional feature macro: CFG_READBACK_EN (read the config frame back and verify it before the DATA command).
module ram_rw_host #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_vld_i,
  output logic            req_rdy_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_size_i,
  input  logic [7:0]      wr_data_i,
  input  logic            wr_vld_i,
  output logic            wr_rdy_o,
  output logic [7:0]      rd_data_o,
  output logic            rd_vld_o,
  input  logic            rd_rdy_i,
  output logic [7:0]      tx_data_o,
  output logic            tx_data_vld_o,
  input  logic            tx_data_rdy_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_data_vld_i,
  output logic            rx_data_rdy_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            fault_o
);

  // Request opcodes
  localparam logic [1:0] OP_RST  = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_LOAD = 2'd2;

  // Protocol command bytes
  localparam logic [7:0] CMD_CPU_RST = 8'h2A;
  localparam logic [7:0] CMD_CPU_RUN = 8'h2B;
  localparam logic [7:0] CMD_CONF_WR = 8'h2C;
  localparam logic [7:0] CMD_DATA_WR = 8'h2E;
  localparam logic [7:0] CMD_DATA_RD = 8'h2F;
`ifdef CFG_READBACK_EN
  localparam logic [7:0] CMD_CONF_RD = 8'h2D;
`endif
  localparam logic [7:0] FAULT_BYTE  = 8'hEF;

  localparam logic [XLEN:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_CFG,
    ST_DATA_TX,
    ST_DATA_RX,
    ST_CHK_CMD,
    ST_CHK_RX
  } state_t;

  // What the byte currently held in CMD is for, i.e. where to go once it is accepted.
  // PH_LAST marks the final LOAD payload byte draining out of the tx register.
  typedef enum logic [1:0] {
    PH_SINGLE,
    PH_CONF,
    PH_DATA,
    PH_LAST
  } phase_t;

  state_t          r_state;
  state_t          w_state_nxt;
  phase_t          r_phase;
  phase_t          w_phase_nxt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_size;
  logic [XLEN:0]   r_cnt;
  logic [7:0]      r_tx_dat;
  logic            r_tx_vld;
  logic            r_done;
  logic            r_err;
  logic            r_fault;

  logic            w_req_hs;
  logic            w_tx_hs;
  logic            w_tx_free;
  logic            w_wr_hs;
  logic            w_rx_hs;
  logic            w_cnt_last;
  logic [2*XLEN-1:0] w_cfg_frame;
  logic [2:0]      w_cfg_idx_nxt;
  logic [7:0]      w_cfg_nxt;
  logic [7:0]      w_data_cmd;

  logic            w_tx_ld;
  logic [7:0]      w_tx_ld_dat;
  logic            w_cnt_clr;
  logic            w_cnt_inc;
  logic            w_done_set;
  logic            w_err_set;

`ifdef CFG_READBACK_EN
  logic            r_mis;
  logic [7:0]      w_cfg_cur;
  logic            w_mis_now;
`endif

  // Handshakes and shared decode
  assign w_req_hs      = req_vld_i & req_rdy_o;
  assign w_tx_hs       = r_tx_vld & tx_data_rdy_i;
  assign w_tx_free     = ~r_tx_vld | tx_data_rdy_i;
  assign w_wr_hs       = wr_vld_i & wr_rdy_o;
  assign w_rx_hs       = rx_data_vld_i & rx_data_rdy_o;
  // Extra counter bit lets size = all-ones be reached without wrapping to zero.
  assign w_cnt_last    = (r_cnt == {1'b0, r_size});
  // Config frame goes out little-endian: addr bytes 0..3, then size bytes 0..3.
  assign w_cfg_frame   = {r_size, r_addr};
  assign w_cfg_idx_nxt = r_cnt[2:0] + 3'd1;
  assign w_cfg_nxt     = w_cfg_frame[{w_cfg_idx_nxt, 3'b000} +: 8];
  assign w_data_cmd    = (r_op == OP_LOAD) ? CMD_DATA_WR : CMD_DATA_RD;

`ifdef CFG_READBACK_EN
  assign w_cfg_cur     = w_cfg_frame[{r_cnt[2:0], 3'b000} +: 8];
  assign w_mis_now     = r_mis | (rx_data_i != w_cfg_cur);
`endif

  assign tx_data_o     = r_tx_dat;
  assign tx_data_vld_o = r_tx_vld;
  assign rd_data_o     = rx_data_i;
  assign done_o        = r_done;
  assign err_o         = r_err;
  assign fault_o       = r_fault;

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_phase <= PH_SINGLE;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // Next-state logic plus the load/count/flag strobes for the datapath
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_tx_ld     = 1'b0;
    w_tx_ld_dat = 8'h00;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_done_set  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req_hs) begin
          w_tx_ld     = 1'b1;
          w_state_nxt = ST_CMD;
          case (req_op_i)
            OP_RST: begin
              w_tx_ld_dat = CMD_CPU_RST;
              w_phase_nxt = PH_SINGLE;
            end
            OP_RUN: begin
              w_tx_ld_dat = CMD_CPU_RUN;
              w_phase_nxt = PH_SINGLE;
            end
            default: begin
              w_tx_ld_dat = CMD_CONF_WR;
              w_phase_nxt = PH_CONF;
            end
          endcase
        end
      end
      ST_CMD: begin
        if (w_tx_hs) begin
          case (r_phase)
            PH_CONF: begin
              w_tx_ld     = 1'b1;
              w_tx_ld_dat = w_cfg_frame[7:0];
              w_cnt_clr   = 1'b1;
              w_state_nxt = ST_CFG;
            end
            PH_DATA: begin
              w_cnt_clr   = 1'b1;
              w_state_nxt = (r_op == OP_LOAD) ? ST_DATA_TX : ST_DATA_RX;
            end
            default: begin
              w_done_set  = 1'b1;
              w_state_nxt = ST_IDLE;
            end
          endcase
        end
      end
      ST_CFG: begin
        if (w_tx_hs) begin
          w_tx_ld = 1'b1;
          if (r_cnt[2:0] != 3'd7) begin
            w_tx_ld_dat = w_cfg_nxt;
            w_cnt_inc   = 1'b1;
          end else begin
`ifdef CFG_READBACK_EN
            w_tx_ld_dat = CMD_CONF_RD;
            w_state_nxt = ST_CHK_CMD;
`else
            w_tx_ld_dat = w_data_cmd;
            w_phase_nxt = PH_DATA;
            w_state_nxt = ST_CMD;
`endif
          end
        end
      end
      ST_DATA_TX: begin
        if (w_wr_hs) begin
          w_tx_ld     = 1'b1;
          w_tx_ld_dat = wr_data_i;
          w_cnt_inc   = 1'b1;
          // Last payload byte is in flight; CMD/PH_LAST waits for it to drain.
          if (w_cnt_last) begin
            w_phase_nxt = PH_LAST;
            w_state_nxt = ST_CMD;
          end
        end
      end
      ST_DATA_RX: begin
        if (w_rx_hs) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
            w_done_set  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
`ifdef CFG_READBACK_EN
      ST_CHK_CMD: begin
        if (w_tx_hs) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = ST_CHK_RX;
        end
      end
      ST_CHK_RX: begin
        if (w_rx_hs) begin
          w_cnt_inc = 1'b1;
          if (r_cnt[2:0] == 3'd7) begin
            if (w_mis_now) begin
              // Target holds a different config: abort before any DATA command.
              w_err_set   = 1'b1;
              w_done_set  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_tx_ld     = 1'b1;
              w_tx_ld_dat = w_data_cmd;
              w_phase_nxt = PH_DATA;
              w_state_nxt = ST_CMD;
            end
          end
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
    // Bytes arriving while we are only transmitting are unexpected.
    if (w_rx_hs && (r_state != ST_IDLE) && (r_state != ST_DATA_RX) && (r_state != ST_CHK_RX)) begin
      w_err_set = 1'b1;
    end
  end

  // Stream-side outputs decoded from the current state
  always_comb begin
    req_rdy_o     = (r_state == ST_IDLE);
    busy_o        = (r_state != ST_IDLE);
    wr_rdy_o      = (r_state == ST_DATA_TX) & w_tx_free;
    rd_vld_o      = (r_state == ST_DATA_RX) & rx_data_vld_i;
    rx_data_rdy_o = (r_state == ST_DATA_RX) ? rd_rdy_i : 1'b1;
  end

  // Request latch, tx byte register, byte counter and status flags
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_op     <= OP_RST;
      r_addr   <= '0;
      r_size   <= '0;
      r_cnt    <= '0;
      r_tx_dat <= 8'h00;
      r_tx_vld <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_op   <= req_op_i;
        r_addr <= req_addr_i;
        r_size <= req_size_i;
      end
      if (w_tx_ld) begin
        r_tx_dat <= w_tx_ld_dat;
        r_tx_vld <= 1'b1;
      end else if (w_tx_hs) begin
        r_tx_vld <= 1'b0;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_ONE;
      end
      r_done  <= w_done_set;
      r_fault <= (r_state == ST_IDLE) & rx_data_vld_i & (rx_data_i == FAULT_BYTE);
      if (w_req_hs) begin
        r_err <= 1'b0;
      end else if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef CFG_READBACK_EN
  // Accumulates any readback byte that differs from the latched frame
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mis <= 1'b0;
    end else if (r_state == ST_CHK_CMD) begin
      r_mis <= 1'b0;
    end else if ((r_state == ST_CHK_RX) && w_rx_hs) begin
      r_mis <= w_mis_now;
    end
  end
`endif

endmodule

// File: tb/tb_ram_rw_host.sv
// Bench for ram_rw_host: randomized requests checked against a protocol-level byte model.
// Expected tx/rd byte lists are built from the command/frame rules; a target emulator feeds rx.
// Build with CFG_READBACK_EN defined to exercise the config readback path as well.
module tb_ram_rw_host;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_vld = 1'b0;
  logic            req_rdy;
  logic [1:0]      req_op = 2'd0;
  logic [XLEN-1:0] req_addr = '0;
  logic [XLEN-1:0] req_size = '0;
  logic [7:0]      wr_data = 8'h00;
  logic            wr_vld = 1'b0;
  logic            wr_rdy;
  logic [7:0]      rd_data;
  logic            rd_vld;
  logic            rd_rdy = 1'b1;
  logic [7:0]      tx_data;
  logic            tx_vld;
  logic            tx_rdy = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_vld = 1'b0;
  logic            rx_rdy;
  logic            busy;
  logic            done;
  logic            err;
  logic            fault;

  ram_rw_host #(.XLEN(XLEN)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_size_i(req_size),
    .wr_data_i(wr_data), .wr_vld_i(wr_vld), .wr_rdy_o(wr_rdy),
    .rd_data_o(rd_data), .rd_vld_o(rd_vld), .rd_rdy_i(rd_rdy),
    .tx_data_o(tx_data), .tx_data_vld_o(tx_vld), .tx_data_rdy_i(tx_rdy),
    .rx_data_i(rx_data), .rx_data_vld_i(rx_vld), .rx_data_rdy_o(rx_rdy),
    .busy_o(busy), .done_o(done), .err_o(err), .fault_o(fault)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Environment state
  logic [7:0] wr_q[$];
  logic [7:0] rx_q[$];
  int         rx_trig_q[$];
  logic [7:0] tx_got[$];
  logic [7:0] rd_got[$];
  logic [7:0] fix_pl[$];
  int cyc = 0;
  int last_hs_cyc = 0;
  int done_cyc = 0;
  int n_done = 0;
  int n_fault = 0;
  int rdy_mode = 0;   // 0: tx ready always, 1: toggling, 2: random
  bit gappy = 1'b0;   // random gaps on wr/rx sources and rd sink

  // One clock: record handshakes just before the edge, check/drive 1 time unit after.
  task automatic step();
    bit acc, wr_acc, rx_acc, hold_pend;
    logic [7:0] hold_dat, dmy8;
    int dmy;
    @(posedge clk);
    cyc++;
    acc    = req_vld & req_rdy;
    wr_acc = wr_vld & wr_rdy;
    rx_acc = rx_vld & rx_rdy;
    if (tx_vld & tx_rdy) begin tx_got.push_back(tx_data); last_hs_cyc = cyc; end
    if (wr_acc) dmy8 = wr_q.pop_front();
    if (rx_acc) begin dmy8 = rx_q.pop_front(); dmy = rx_trig_q.pop_front(); last_hs_cyc = cyc; end
    if (rd_vld & rd_rdy) rd_got.push_back(rd_data);
    if (done) begin n_done++; done_cyc = cyc; end
    if (fault) n_fault++;
    hold_pend = tx_vld & ~tx_rdy;
    hold_dat  = tx_data;
    #1;
    if (hold_pend) begin
      chk("tx_hold_vld", tx_vld, 1);
      chk("tx_hold_dat", tx_data, hold_dat);
    end
    if (acc) begin
      chk("tx_vld_lat1", tx_vld, 1);
      chk("busy_after_accept", busy, 1);
      req_vld = 1'b0;
    end
    case (rdy_mode)
      0: tx_rdy = 1'b1;
      1: tx_rdy = ~tx_rdy;
      default: tx_rdy = 1'($urandom_range(0, 1));
    endcase
    rd_rdy = gappy ? 1'($urandom_range(0, 3) != 0) : 1'b1;
    if (!(wr_vld && !wr_acc)) begin
      if (wr_q.size() > 0 && (!gappy || $urandom_range(0, 2) != 0)) begin
        wr_vld = 1'b1; wr_data = wr_q[0];
      end else wr_vld = 1'b0;
    end
    if (!(rx_vld && !rx_acc)) begin
      if (rx_q.size() > 0 && tx_got.size() >= rx_trig_q[0] && (!gappy || $urandom_range(0, 2) != 0)) begin
        rx_vld = 1'b1; rx_data = rx_q[0];
      end else rx_vld = 1'b0;
    end
  endtask

  task automatic clear_env();
    wr_q = {}; rx_q = {}; rx_trig_q = {}; tx_got = {}; rd_got = {};
    n_done = 0; n_fault = 0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_req_rdy"}, req_rdy, 1);
    chk({pfx, "_tx_data"}, tx_data, 0);
    chk({pfx, "_tx_vld"},  tx_vld, 0);
    chk({pfx, "_wr_rdy"},  wr_rdy, 0);
    chk({pfx, "_rd_vld"},  rd_vld, 0);
    chk({pfx, "_rx_rdy"},  rx_rdy, 1);
    chk({pfx, "_busy"},    busy, 0);
    chk({pfx, "_done"},    done, 0);
    chk({pfx, "_err"},     err, 0);
    chk({pfx, "_fault"},   fault, 0);
  endtask

  // Builds the expected byte traffic from protocol rules, runs one request, compares.
  // corrupt >= 0 flips readback byte 'corrupt' (only meaningful with readback enabled).
  task automatic run_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] size,
                         input int corrupt);
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rd[$];
    logic [7:0] cfg[8];
    logic [7:0] b;
    bit mismatch = 1'b0;
    int n;
    clear_env();
    for (int i = 0; i < 4; i++) begin
      cfg[i]     = addr[8*i +: 8];
      cfg[4 + i] = size[8*i +: 8];
    end
    if (op == 2'd0) exp_tx.push_back(8'h2A);
    else if (op == 2'd1) exp_tx.push_back(8'h2B);
    else begin
      exp_tx.push_back(8'h2C);
      for (int i = 0; i < 8; i++) exp_tx.push_back(cfg[i]);
`ifdef CFG_READBACK_EN
      exp_tx.push_back(8'h2D);
      for (int i = 0; i < 8; i++) begin
        b = cfg[i];
        if (i == corrupt) b = b + 8'd1;
        rx_q.push_back(b);
        rx_trig_q.push_back(exp_tx.size());
      end
      mismatch = (corrupt >= 0);
`endif
      if (!mismatch) begin
        exp_tx.push_back(op == 2'd2 ? 8'h2E : 8'h2F);
        n = int'(size) + 1;
        for (int i = 0; i < n; i++) begin
          b = (i < fix_pl.size()) ? fix_pl[i] : 8'($urandom_range(0, 255));
          if (op == 2'd2) begin
            wr_q.push_back(b);
            exp_tx.push_back(b);
          end else begin
            rx_q.push_back(b);
            rx_trig_q.push_back(exp_tx.size());
            exp_rd.push_back(b);
          end
        end
      end
    end
    req_op = op; req_addr = addr; req_size = size; req_vld = 1'b1;
    for (int k = 0; k < 3000 && n_done == 0; k++) step();
    req_vld = 1'b0;
    for (int k = 0; k < 3; k++) step();
    chk($sformatf("done_count op%0d", op), n_done, 1);
    chk("done_timing", done_cyc, last_hs_cyc + 1);
    chk("tx_len", tx_got.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
      chk($sformatf("tx_byte[%0d]", i), tx_got[i], exp_tx[i]);
    chk("rd_len", rd_got.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_got.size(); i++)
      chk($sformatf("rd_byte[%0d]", i), rd_got[i], exp_rd[i]);
    chk("busy_end", busy, 0);
    chk("req_rdy_end", req_rdy, 1);
    chk("err_end", err, mismatch);
    fix_pl = {};
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_addr, r_size;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-byte commands
    run_req(2'd1, 32'h0, 32'h0, -1);
    run_req(2'd0, 32'h0, 32'h0, -1);

    // Directed LOAD and DUMP
    fix_pl = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_req(2'd2, 32'h0000_0010, 32'd3, -1);
    fix_pl = '{8'hA5, 8'h5A};
    run_req(2'd3, 32'h0100_0000, 32'd1, -1);

    // LOAD under toggling tx ready with gappy payload source
    rdy_mode = 1; gappy = 1'b1;
    run_req(2'd2, 32'h0000_0010, 32'd3, -1);

    // Randomized requests
    for (int t = 0; t < 10; t++) begin
      rdy_mode = $urandom_range(0, 2);
      gappy    = 1'($urandom_range(0, 1));
      r_op     = 2'($urandom_range(0, 3));
      r_addr   = $urandom;
      r_size   = $urandom_range(0, 9);
      run_req(r_op, r_addr, r_size, -1);
    end
    rdy_mode = 0; gappy = 1'b0;

    // Unsolicited bytes in IDLE: only 0xEF raises fault
    clear_env();
    rx_q.push_back(8'h3C); rx_trig_q.push_back(0);
    repeat (5) step();
    chk("no_fault_other_byte", n_fault, 0);
    clear_env();
    rx_q.push_back(8'hEF); rx_trig_q.push_back(0);
    repeat (5) step();
    chk("fault_pulse_count", n_fault, 1);
    chk("fault_no_err", err, 0);

    // Reset while streaming LOAD payload
    clear_env();
    rdy_mode = 2; gappy = 1'b1;
    for (int i = 0; i < 21; i++) wr_q.push_back(8'($urandom_range(0, 255)));
    req_op = 2'd2; req_addr = $urandom; req_size = 32'd20; req_vld = 1'b1;
    for (int k = 0; k < 400 && tx_got.size() < 13; k++) step();
    req_vld = 1'b0;
    chk("reached_data_tx", tx_got.size() >= 13, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    clear_env();
    wr_vld = 1'b0; rx_vld = 1'b0; rdy_mode = 0; gappy = 1'b0; tx_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) step();
    chk("no_tx_after_reset", tx_got.size(), 0);
    run_req(2'd0, 32'h0, 32'h0, -1);
    run_req(2'd2, 32'h0000_0200, 32'd2, -1);

`ifdef CFG_READBACK_EN
    // Readback returns 0x04 where size byte 0x03 was sent
    run_req(2'd2, 32'h0000_0010, 32'd3, 4);
    run_req(2'd3, 32'h0000_0040, 32'd2, -1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
